// File: rtl/b10_down_counter.sv
// Multi-digit BCD down counter with parallel load, wrap/stop-at-zero mode,
// borrow-out for cascading, a terminal-count done pulse and a bad-load err pulse.
module b10_down_counter #(
  parameter int DIGITS = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   d,
  input  logic                  ei,
  input  logic                  wrap,
  output logic [4*DIGITS-1:0]   q,
  output logic                  eu,
  output logic                  zero,
  output logic                  done,
  output logic                  err
);

  localparam logic [4*DIGITS-1:0] VALUE_ONE = {{(4*DIGITS-1){1'b0}}, 1'b1};

  logic [4*DIGITS-1:0] count_q, count_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                zero_s;

  // Non-BCD load digits are forced to 9 so q never holds an illegal digit.
  function automatic logic [3:0] clamp_digit(input logic [3:0] v);
    clamp_digit = (v > 4'd9) ? 4'd9 : v;
  endfunction

  function automatic logic [3:0] dec_digit(input logic [3:0] v);
    dec_digit = (v == 4'd0) ? 4'd9 : (v - 4'd1);
  endfunction

  assign zero_s = (count_q == {(4*DIGITS){1'b0}});

  // Next-state logic: load beats decrement beats hold.
  always_comb begin
    logic                borrow;
    logic                bad;
    logic [4*DIGITS-1:0] load_val;
    logic [4*DIGITS-1:0] dec_val;

    count_d  = count_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    borrow   = 1'b1;
    bad      = 1'b0;
    load_val = {(4*DIGITS){1'b0}};
    dec_val  = count_q;

    for (int i = 0; i < DIGITS; i++) begin
      load_val[4*i +: 4] = clamp_digit(d[4*i +: 4]);
      if (d[4*i +: 4] > 4'd9) begin
        bad = 1'b1;
      end else begin
        bad = bad;
      end
      // A digit borrows only when every lower digit is already zero.
      if (borrow) begin
        dec_val[4*i +: 4] = dec_digit(count_q[4*i +: 4]);
      end else begin
        dec_val[4*i +: 4] = count_q[4*i +: 4];
      end
      borrow = borrow & (count_q[4*i +: 4] == 4'd0);
    end

    if (load) begin
      count_d = load_val;
      err_d   = bad;
    end else if (ei) begin
      done_d = (count_q == VALUE_ONE);
      if (zero_s && !wrap) begin
        count_d = count_q;
      end else begin
        count_d = dec_val;
      end
    end else begin
      count_d = count_q;
    end
  end

  // State and registered flags; reset overrides everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= {(4*DIGITS){1'b0}};
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign q    = count_q;
  assign zero = zero_s;
  assign eu   = ei & zero_s;
  assign done = done_q;
  assign err  = err_q;

endmodule
